// File: rtl/conv_fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
// The optional burst timeout is enabled by defining CONV_FIFO_ARB_TIMEOUT_EN.
package conv_fifo_arb_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } arbState_e;

    localparam int DefBurstLen   = 16;
    localparam int DefTimeoutCyc = 64;

    // Width shared by the beat counter (0..BURST_LEN-1) and idle counter (0..TIMEOUT_CYC-1).
    function automatic int cntWidth(input int burstLen, input int timeoutCyc);
        int w;
        w = $clog2(burstLen);
        if ($clog2(timeoutCyc) > w) w = $clog2(timeoutCyc);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/conv_rr_pick.sv
// Combinational round-robin picker: first requester after last_winner_i, wrapping.
module conv_rr_pick
    import conv_fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_winner_i,
    output logic [N_REQ-1:0] winner_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((int'(last_winner_i) + k) % N_REQ);
            if (!valid_o && req_i[idx]) begin
                winner_o[idx] = 1'b1;
                valid_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_fifo_wr_arb.sv
// Grants one requester at a time a BURST_LEN-beat burst into a shared FIFO write port.
// Define CONV_FIFO_ARB_TIMEOUT_EN to abort bursts whose source stays idle TIMEOUT_CYC cycles.
module conv_fifo_wr_arb
    import conv_fifo_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 32,
    parameter int DEPTH_W     = 10,
    parameter int BURST_LEN   = DefBurstLen,
    parameter int TIMEOUT_CYC = DefTimeoutCyc
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ-1:0]        src_valid_i,
    input  logic [N_REQ*DATA_W-1:0] src_data_i,
    output logic [N_REQ-1:0]        src_ready_o,
    output logic [N_REQ-1:0]        gnt_o,
    output logic                    burst_done_o,
    output logic                    burst_abort_o,
    output logic                    fifo_wr_en_o,
    output logic [DATA_W-1:0]       fifo_wr_data_o,
    input  logic                    fifo_wr_full_i,
    input  logic [DEPTH_W:0]        fifo_wr_water_level_i
);

    localparam int IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CntW = cntWidth(BURST_LEN, TIMEOUT_CYC);
    localparam logic [DEPTH_W:0]  Capacity   = {1'b1, {DEPTH_W{1'b0}}};
    localparam logic [DEPTH_W:0]  BurstWords = (DEPTH_W+1)'(BURST_LEN);
    localparam logic [CntW-1:0]   LastBeat   = CntW'(BURST_LEN - 1);

    arbState_e         state_q;
    logic [N_REQ-1:0]  gnt_q;
    logic [IdxW-1:0]   gntIdx_q;
    logic [IdxW-1:0]   lastWinner_q;
    logic [CntW-1:0]   beatCnt_q;
    logic [CntW-1:0]   beatCnt_d;

    logic [N_REQ-1:0]  pickWinner;
    logic              pickValid;
    logic [IdxW-1:0]   pickIdx;
    logic [DEPTH_W:0]  freeWords;
    logic              startOk;
    logic              beat;
    logic              doneNow;
    logic              abortNow;
    logic [DATA_W-1:0] dataMux;

    conv_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IdxW)
    ) uPick (
        .req_i         (req_i),
        .last_winner_i (lastWinner_q),
        .winner_o      (pickWinner),
        .valid_o       (pickValid)
    );

    always_comb begin
        pickIdx = '0;
        dataMux = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pickWinner[i]) pickIdx = IdxW'(i);
            if (gnt_q[i])      dataMux = src_data_i[i*DATA_W +: DATA_W];
        end
    end

    // A burst only starts when the whole burst is guaranteed to fit in the FIFO.
    assign freeWords = Capacity - fifo_wr_water_level_i;
    assign startOk   = pickValid && !fifo_wr_full_i && (freeWords >= BurstWords);

    assign src_ready_o = gnt_q & {N_REQ{!fifo_wr_full_i}};
    assign beat        = |(src_valid_i & src_ready_o);
    assign doneNow     = beat && (beatCnt_q == LastBeat);
    assign beatCnt_d   = beat ? beatCnt_q + 1'b1 : beatCnt_q;

`ifdef CONV_FIFO_ARB_TIMEOUT_EN
    logic [CntW-1:0] idleCnt_q;
    logic [CntW-1:0] idleCnt_d;
    logic            idleCycle;

    assign idleCycle = |(src_ready_o & ~src_valid_i);
    assign abortNow  = idleCycle && (idleCnt_q == CntW'(TIMEOUT_CYC - 1));
    assign idleCnt_d = beat ? '0 : (idleCycle ? idleCnt_q + 1'b1 : idleCnt_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                  idleCnt_q <= '0;
        else if (doneNow || abortNow) idleCnt_q <= '0;
        else                          idleCnt_q <= idleCnt_d;
    end
`else
    assign abortNow = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            gntIdx_q     <= '0;
            lastWinner_q <= IdxW'(N_REQ - 1);
            beatCnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (startOk) begin
                        state_q   <= BURST;
                        gnt_q     <= pickWinner;
                        gntIdx_q  <= pickIdx;
                        beatCnt_q <= '0;
                    end
                end
                BURST: begin
                    if (doneNow || abortNow) begin
                        state_q      <= IDLE;
                        gnt_q        <= '0;
                        lastWinner_q <= gntIdx_q;
                        beatCnt_q    <= '0;
                    end else begin
                        beatCnt_q <= beatCnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o          = gnt_q;
    assign fifo_wr_en_o   = beat;
    assign fifo_wr_data_o = dataMux;
    assign burst_done_o   = doneNow;
    assign burst_abort_o  = abortNow;

endmodule

// File: tb/tb_conv_fifo_wr_arb.sv
// Scoreboard bench for conv_fifo_wr_arb: expected beats are queued as stimulus is
// driven and popped whenever the arbiter writes the FIFO.
module tb_conv_fifo_wr_arb;

    localparam int NReq   = 4;
    localparam int DataW  = 32;
    localparam int DepthW = 10;

    logic                  clk = 1'b0;
    logic                  rstN;
    logic [NReq-1:0]       req;
    logic [NReq-1:0]       srcValid;
    logic [NReq*DataW-1:0] srcData;
    logic [NReq-1:0]       srcReady;
    logic [NReq-1:0]       gnt;
    logic                  burstDone;
    logic                  burstAbort;
    logic                  fifoWrEn;
    logic [DataW-1:0]      fifoWrData;
    logic                  fifoWrFull;
    logic [DepthW:0]       waterLevel;

    typedef struct {
        logic [DataW-1:0] data;
        logic             last;
    } beat_t;

    beat_t           sbQ[$];
    int              compared   = 0;
    int              mismatched = 0;
    int              seq[NReq];
    int              expSeq[NReq];
    logic [NReq-1:0] acc     = '0;
    logic            abortOk = 1'b0;

    conv_fifo_wr_arb uDut (
        .clk_i                 (clk),
        .rst_ni                (rstN),
        .req_i                 (req),
        .src_valid_i           (srcValid),
        .src_data_i            (srcData),
        .src_ready_o           (srcReady),
        .gnt_o                 (gnt),
        .burst_done_o          (burstDone),
        .burst_abort_o         (burstAbort),
        .fifo_wr_en_o          (fifoWrEn),
        .fifo_wr_data_o        (fifoWrData),
        .fifo_wr_full_i        (fifoWrFull),
        .fifo_wr_water_level_i (waterLevel)
    );

    always #5 clk = ~clk;

    function automatic logic [DataW-1:0] mkData(input int idx, input int s);
        return {8'(idx), 24'(s)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NReq-1:0] r, input logic [NReq-1:0] v,
                                 input int level, input logic full);
        req        = r;
        srcValid   = v;
        waterLevel = (DepthW+1)'(level);
        fifoWrFull = full;
    endtask

    task automatic pushBeats(input int idx, input int n, input logic lastAtEnd);
        for (int k = 0; k < n; k++) begin
            beat_t b;
            b.data = mkData(idx, expSeq[idx]);
            b.last = lastAtEnd && (k == n - 1);
            sbQ.push_back(b);
            expSeq[idx]++;
        end
    endtask

    task automatic expectBeats(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            checkOutput(tag, fifoWrEn, 1'b1);
        end
    endtask

    task automatic doReset();
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        tick();
    endtask

    // Source model: each requester presents a running sequence number, advanced on acceptance.
    initial begin
        for (int i = 0; i < NReq; i++) begin
            seq[i] = 0;
            srcData[i*DataW +: DataW] = mkData(i, 0);
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NReq; i++) begin
                if (acc[i]) seq[i]++;
                srcData[i*DataW +: DataW] = mkData(i, seq[i]);
            end
        end
    end

    // Output monitor: every FIFO write must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            acc = srcValid & srcReady;
            if (fifoWrEn) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedBeat", fifoWrEn, 1'b0);
                end else begin
                    beat_t b;
                    b = sbQ.pop_front();
                    checkOutput("beatData", fifoWrData, b.data);
                    checkOutput("beatDone", burstDone, b.last);
                end
            end else if (burstDone) begin
                checkOutput("strayDone", burstDone, 1'b0);
            end
            if (burstAbort) checkOutput("abortPulse", burstAbort, abortOk);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ord[5];
        ord = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NReq; i++) expSeq[i] = 0;

        rstN = 1'b0;
        applyStimulus(4'b1111, 4'b1111, 0, 1'b0);
        tick();
        tick();
        checkOutput("rstGnt",      gnt,        4'b0000);
        checkOutput("rstSrcReady", srcReady,   4'b0000);
        checkOutput("rstWrEn",     fifoWrEn,   1'b0);
        checkOutput("rstDone",     burstDone,  1'b0);
        checkOutput("rstAbort",    burstAbort, 1'b0);
        req  = '0;
        rstN = 1'b1;
        tick();

        $display("[TB] single requester burst");
        applyStimulus(4'b0001, 4'b1111, 0, 1'b0);
        pushBeats(0, 16, 1'b1);
        tick();
        checkOutput("c1Gnt", gnt, 4'b0001);
        req = '0;
        expectBeats("c1Beat", 16);
        tick();
        checkOutput("c1GntClr", gnt, 4'b0000);

        $display("[TB] round robin with all requesters");
        doReset();
        applyStimulus(4'b1111, 4'b1111, 0, 1'b0);
        for (int b = 0; b < 5; b++) pushBeats(ord[b], 16, 1'b1);
        for (int b = 0; b < 5; b++) begin
            tick();
            checkOutput("c2Gnt", gnt, 32'(1) << ord[b]);
            if (b == 4) req = '0;
            expectBeats("c2Beat", 16);
            tick();
            checkOutput("c2Gap", gnt, 4'b0000);
        end

        $display("[TB] free-space threshold");
        applyStimulus(4'b0010, 4'b1111, 1009, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("c3NoGnt", gnt, 4'b0000);
        end
        waterLevel = (DepthW+1)'(1008);
        pushBeats(1, 16, 1'b1);
        tick();
        checkOutput("c3Gnt", gnt, 4'b0010);
        applyStimulus(4'b0000, 4'b1111, 0, 1'b0);
        expectBeats("c3Beat", 16);
        tick();
        checkOutput("c3GntClr", gnt, 4'b0000);

        $display("[TB] full stall mid burst");
        applyStimulus(4'b0001, 4'b1111, 0, 1'b0);
        pushBeats(0, 16, 1'b1);
        tick();
        checkOutput("c4Gnt", gnt, 4'b0001);
        req = '0;
        expectBeats("c4Beat", 5);
        tick();
        fifoWrFull = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("c4StallReady", srcReady,   4'b0000);
            checkOutput("c4StallWrEn",  fifoWrEn,   1'b0);
            checkOutput("c4NoAbort",    burstAbort, 1'b0);
        end
        tick();
        fifoWrFull = 1'b0;
        expectBeats("c4Beat", 11);
        tick();
        checkOutput("c4GntClr", gnt, 4'b0000);

`ifdef CONV_FIFO_ARB_TIMEOUT_EN
        $display("[TB] idle source timeout");
        applyStimulus(4'b0110, 4'b1111, 0, 1'b0);
        pushBeats(1, 3, 1'b0);
        tick();
        checkOutput("c5Gnt", gnt, 4'b0010);
        req = 4'b0100;
        expectBeats("c5Beat", 3);
        tick();
        srcValid = 4'b1101;
        abortOk  = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k == 63) checkOutput("c5PreAbort", burstAbort, 1'b0);
            if (k == 64) checkOutput("c5Abort",    burstAbort, 1'b1);
        end
        tick();
        abortOk = 1'b0;
        checkOutput("c5GntClr", gnt, 4'b0000);
        srcValid = 4'b1111;
        pushBeats(2, 16, 1'b1);
        tick();
        checkOutput("c5NextGnt", gnt, 4'b0100);
        req = '0;
        expectBeats("c5NextBeat", 16);
        tick();
        checkOutput("c5NextClr", gnt, 4'b0000);
`endif

        $display("[TB] reset mid burst");
        applyStimulus(4'b0001, 4'b1111, 0, 1'b0);
        pushBeats(0, 16, 1'b1);
        tick();
        checkOutput("c6Gnt", gnt, 4'b0001);
        req = '0;
        expectBeats("c6Beat", 7);
        tick();
        rstN = 1'b0;
        #1;
        checkOutput("c6RstGnt",   gnt,        4'b0000);
        checkOutput("c6RstReady", srcReady,   4'b0000);
        checkOutput("c6RstWrEn",  fifoWrEn,   1'b0);
        checkOutput("c6RstDone",  burstDone,  1'b0);
        checkOutput("c6RstAbort", burstAbort, 1'b0);
        checkOutput("c6Left",     sbQ.size(), 9);
        while (sbQ.size() > 0) void'(sbQ.pop_front());
        expSeq[0] -= 9;
        req = 4'b1111;
        tick();
        rstN = 1'b1;
        pushBeats(0, 16, 1'b1);
        tick();
        checkOutput("c6FirstGnt", gnt, 4'b0001);
        req = '0;
        expectBeats("c6AfterBeat", 16);
        tick();
        checkOutput("c6GntClr", gnt, 4'b0000);

        checkOutput("sbEmpty", sbQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
